// File: rtl/gbar_unit.sv
// Global barrier controller: tracks arrivals per barrier id and pulses a release.
// Optional protocol checking on err is enabled by defining GBAR_ERR_CHECK_EN.
module gbar_unit #(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    localparam int BID_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [BID_W-1:0] req_id,
    input  logic [CID_W-1:0] req_size_m1,
    input  logic [CID_W-1:0] req_core_id,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [BID_W-1:0] rsp_id,
    input  logic             flush,
    output logic             flush_busy,
    output logic             err
);

    localparam logic [BID_W:0]   ID_LIM   = NUM_BARRIERS[BID_W:0];
    localparam logic [CID_W:0]   CORE_LIM = NUM_CORES[CID_W:0];
    localparam logic [BID_W-1:0] IDX_LAST = BID_W'(NUM_BARRIERS - 1);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BID_W-1:0] r_idx;
    logic [BID_W-1:0] w_idx_nxt;
    logic             w_ready;
    logic             w_busy;

    logic [NUM_CORES-1:0] r_mask   [NUM_BARRIERS];
    logic [CID_W:0]       r_cnt    [NUM_BARRIERS];
    logic [CID_W-1:0]     r_size   [NUM_BARRIERS];
    logic                 r_active [NUM_BARRIERS];

    logic             r_rsp_valid;
    logic [BID_W-1:0] r_rsp_id;

    logic                 w_fire;
    logic                 w_id_ok;
    logic                 w_core_ok;
    logic [BID_W-1:0]     w_sel;
    logic                 w_act;
    logic [NUM_CORES-1:0] w_msk;
    logic [CID_W:0]       w_cnt;
    logic [CID_W-1:0]     w_size;
    logic [NUM_CORES-1:0] w_oh;
    logic                 w_dup;
    logic [CID_W:0]       w_cnt_nxt;
    logic [CID_W:0]       w_lim;
    logic                 w_take;
    logic                 w_release;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                    w_idx_nxt   = '0;
                end
            end
            S_FLUSH: begin
                w_busy    = 1'b1;
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // flush wins over a same-cycle request even though ready is still high
    assign w_fire    = req_valid && w_ready && !flush;
    assign w_id_ok   = {1'b0, req_id} < ID_LIM;
    assign w_core_ok = {1'b0, req_core_id} < CORE_LIM;
    assign w_sel     = w_id_ok ? req_id : '0;
    assign w_act     = r_active[w_sel];
    assign w_msk     = r_mask[w_sel];
    assign w_cnt     = r_cnt[w_sel];
    assign w_size    = r_size[w_sel];
    assign w_oh      = w_core_ok ? (NUM_CORES'(1) << req_core_id) : '0;
    assign w_dup     = w_act && (|(w_msk & w_oh));
    assign w_cnt_nxt = w_act ? (w_cnt + 1'b1) : (CID_W+1)'(1);
    assign w_lim     = w_act ? ({1'b0, w_size} + 1'b1)
                             : ({1'b0, req_size_m1} + 1'b1);
    assign w_take    = w_fire && w_id_ok && w_core_ok && !w_dup;
    assign w_release = w_take && (w_cnt_nxt == w_lim);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_mask[b]   <= '0;
                r_cnt[b]    <= '0;
                r_size[b]   <= '0;
                r_active[b] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (r_state == S_FLUSH && r_idx == BID_W'(b)) begin
                    r_mask[b]   <= '0;
                    r_cnt[b]    <= '0;
                    r_size[b]   <= '0;
                    r_active[b] <= 1'b0;
                end else if (w_take && w_sel == BID_W'(b)) begin
                    if (w_release) begin
                        r_mask[b]   <= '0;
                        r_cnt[b]    <= '0;
                        r_active[b] <= 1'b0;
                    end else begin
                        r_mask[b]   <= w_msk | w_oh;
                        r_cnt[b]    <= w_cnt_nxt;
                        r_active[b] <= 1'b1;
                        if (!w_act) r_size[b] <= req_size_m1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_release;
            if (w_release) r_rsp_id <= req_id;
        end
    end

    assign req_ready  = w_ready;
    assign flush_busy = w_busy;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;

`ifdef GBAR_ERR_CHECK_EN
    logic r_err;
    logic w_err_hit;

    assign w_err_hit = w_fire && (!w_id_ok || !w_core_ok || w_dup ||
                       (w_act && req_size_m1 != w_size));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else if (w_err_hit) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gbar_unit.sv
// Directed self-checking bench for gbar_unit (NUM_BARRIERS=4, NUM_CORES=4).
module tb_gbar_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_id;
    logic [1:0] req_size_m1;
    logic [1:0] req_core_id;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       flush;
    logic       flush_busy;
    logic       err;

    int errors = 0;
    int checks = 0;

`ifdef GBAR_ERR_CHECK_EN
    localparam logic ERR_DUP = 1'b1;
`else
    localparam logic ERR_DUP = 1'b0;
`endif

    always #5 clk = ~clk;

    gbar_unit #(.NUM_BARRIERS(4), .NUM_CORES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_core_id (req_core_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .flush       (flush),
        .flush_busy  (flush_busy),
        .err         (err)
    );

    // one request for one cycle; returns 1ns after the capturing edge
    task automatic drive(input logic [1:0] id, input logic [1:0] sz,
                         input logic [1:0] core);
        req_valid   = 1'b1;
        req_id      = id;
        req_size_m1 = sz;
        req_core_id = core;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
        end
        checks++;
        if (rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id);
        end
        checks++;
        if (flush_busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_err got=%b%b exp=00", flush_busy, err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < 3; c++) begin
            drive(2'd2, 2'd3, 2'(c));
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early c=%0d got=%b exp=0", c, rsp_valid);
            end
        end
        drive(2'd2, 2'd3, 2'd3);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL basic_release got=%b/%0d exp=1/2", rsp_valid, rsp_id);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_pulse got=%b exp=0", rsp_valid);
        end
        // id 2 must be empty: a fresh size-0 arrival releases at once
        drive(2'd2, 2'd0, 2'd1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL basic_cleared got=%b/%0d exp=1/2", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_single();
        @(posedge clk);
        #1;
        drive(2'd0, 2'd0, 2'd1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single got=%b/%0d exp=1/0", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_interleave();
        logic [1:0] ids [6];
        logic [1:0] cores [6];
        logic       expv [6];
        ids   = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1};
        cores = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1};
        expv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            drive(ids[k], 2'd1, cores[k]);
            checks++;
            if (rsp_valid !== expv[k] || (expv[k] && rsp_id !== ids[k])) begin
                errors++;
                $display("FAIL interleave k=%0d got=%b/%0d exp=%b/%0d",
                         k, rsp_valid, rsp_id, expv[k], ids[k]);
            end
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        drive(2'd0, 2'd1, 2'd2);
        drive(2'd0, 2'd1, 2'd2);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL dup_no_release got=%b exp=0", rsp_valid);
        end
        checks++;
        if (err !== ERR_DUP) begin
            errors++;
            $display("FAIL dup_err got=%b exp=%b", err, ERR_DUP);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL dup_ready got=%b exp=1", req_ready);
        end
        drive(2'd0, 2'd1, 2'd3);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL dup_release got=%b/%0d exp=1/0", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(2'd1, 2'd2, 2'd0);
        drive(2'd1, 2'd2, 2'd1);
        // third arrival collides with flush and must be refused
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_id      = 2'd1;
        req_size_m1 = 2'd2;
        req_core_id = 2'd2;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (flush_busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_cyc k=%0d busy/ready/rsp got=%b%b%b exp=100",
                         k, flush_busy, req_ready, rsp_valid);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (flush_busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done busy/ready got=%b%b exp=01", flush_busy, req_ready);
        end
        drive(2'd1, 2'd2, 2'd2);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cleared got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(2'd3, 2'd2, 2'd0);
        drive(2'd3, 2'd2, 2'd1);
        drive(2'd0, 2'd0, 2'd0);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got=%b exp=1", rsp_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || flush_busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL areset_now rsp/id/busy/err got=%b/%0d/%b/%b exp=0/0/0/0",
                     rsp_valid, rsp_id, flush_busy, err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(2'd3, 2'd2, 2'd2);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_lost got=%b exp=0", rsp_valid);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_id      = '0;
        req_size_m1 = '0;
        req_core_id = '0;
        flush       = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_interleave();
        test_duplicate();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
